// File: rtl/deconv_pkg.sv
// Shared constants for the nibble deconvolution unit: widths, packing layout,
// FSM states and the mod-16 multiplicative inverse table.
package deconv_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int TAPS      = 4;
  localparam int Y_NIBBLES = 2 * TAPS - 1;
  localparam int Y_W       = NIBBLE_W * Y_NIBBLES;
  localparam int H_W       = NIBBLE_W * TAPS;
  localparam int X_W       = NIBBLE_W * TAPS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_SOLVE,
    S_CHECK,
    S_DONE
  } state_t;

  // Even entries have no inverse mod 16 and are never selected.
  localparam logic [NIBBLE_W-1:0] INV_LUT [16] = '{
    4'd0, 4'd1,  4'd0, 4'd11, 4'd0, 4'd13, 4'd0, 4'd7,
    4'd0, 4'd9,  4'd0, 4'd3,  4'd0, 4'd5,  4'd0, 4'd15
  };

endpackage

// File: rtl/deconv_mac.sv
// Combinational mod-16 sum of up to three nibble products, shared by the
// back-substitution and consistency-check phases.
module deconv_mac
  import deconv_pkg::*;
(
  input  logic [3*NIBBLE_W-1:0] coef,
  input  logic [3*NIBBLE_W-1:0] data,
  input  logic [2:0]            term_en,
  output logic [NIBBLE_W-1:0]   sum
);

  always_comb begin
    sum = '0;
    for (int t = 0; t < 3; t++) begin
      if (term_en[t]) begin
        sum = sum + NIBBLE_W'(coef[t*NIBBLE_W +: NIBBLE_W] * data[t*NIBBLE_W +: NIBBLE_W]);
      end
    end
  end

endmodule

// File: rtl/deconvolution.sv
// Sequential mod-16 deconvolution: recovers x from y = h * x one nibble per cycle.
// Define DECONV_CHECK_EN to verify y4..y6 against the recovered x (err_mismatch).
module deconvolution
  import deconv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] y_in,
  input  logic [31:0] h_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_out,
  output logic        err_noninv,
  output logic        err_mismatch
);

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [H_W-1:0]        h_q, h_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [NIBBLE_W-1:0]   inv_q, inv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_noninv_q, err_noninv_d;
`ifdef DECONV_CHECK_EN
  logic                  err_mismatch_q, err_mismatch_d;
`endif

  logic [3*NIBBLE_W-1:0] mac_coef, mac_data;
  logic [2:0]            mac_en;
  logic [NIBBLE_W-1:0]   mac_sum;
  logic [NIBBLE_W-1:0]   y_k;
  logic [NIBBLE_W-1:0]   solve_acc;
  logic                  unused_bits;

  assign unused_bits = ^{y_in[31:Y_W], h_in[31:H_W]};

  // Term j pairs h_j with x_(k-j); it contributes only while k-j indexes a real x nibble.
  always_comb begin
    mac_coef = '0;
    mac_data = '0;
    mac_en   = '0;
    for (int j = 1; j < TAPS; j++) begin
      mac_coef[(j-1)*NIBBLE_W +: NIBBLE_W] = h_q[j*NIBBLE_W +: NIBBLE_W];
      mac_en[j-1] = (k_q >= 3'(j)) && ((k_q - 3'(j)) < 3'(TAPS));
      mac_data[(j-1)*NIBBLE_W +: NIBBLE_W] = x_q[{2'(k_q - 3'(j)), 2'b00} +: NIBBLE_W];
    end
  end

  deconv_mac u_mac (
    .coef    (mac_coef),
    .data    (mac_data),
    .term_en (mac_en),
    .sum     (mac_sum)
  );

  always_comb begin
    y_k = '0;
    for (int i = 0; i < Y_NIBBLES; i++) begin
      if (k_q == 3'(i)) y_k = y_q[i*NIBBLE_W +: NIBBLE_W];
    end
  end

  assign solve_acc = y_k - mac_sum;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    y_d          = y_q;
    h_d          = h_q;
    x_d          = x_q;
    inv_d        = inv_q;
    done_d       = 1'b0;
    err_noninv_d = err_noninv_q;
`ifdef DECONV_CHECK_EN
    err_mismatch_d = err_mismatch_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          y_d          = y_in[Y_W-1:0];
          h_d          = h_in[H_W-1:0];
          x_d          = '0;
          err_noninv_d = 1'b0;
`ifdef DECONV_CHECK_EN
          err_mismatch_d = 1'b0;
`endif
          k_d          = '0;
          state_d      = S_INV;
        end
      end
      S_INV: begin
        if (!h_q[0]) begin
          err_noninv_d = 1'b1;
          done_d       = 1'b1;
          state_d      = S_DONE;
        end else begin
          inv_d   = INV_LUT[h_q[NIBBLE_W-1:0]];
          state_d = S_SOLVE;
        end
      end
      S_SOLVE: begin
        x_d[{k_q[1:0], 2'b00} +: NIBBLE_W] = NIBBLE_W'(solve_acc * inv_q);
        if (k_q == 3'(TAPS - 1)) begin
`ifdef DECONV_CHECK_EN
          k_d     = 3'(TAPS);
          state_d = S_CHECK;
`else
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          k_d = k_q + 3'd1;
        end
      end
`ifdef DECONV_CHECK_EN
      S_CHECK: begin
        if (mac_sum != y_k) err_mismatch_d = 1'b1;
        if (k_q == 3'(Y_NIBBLES - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      y_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      inv_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_noninv_q <= 1'b0;
`ifdef DECONV_CHECK_EN
      err_mismatch_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      y_q          <= y_d;
      h_q          <= h_d;
      x_q          <= x_d;
      inv_q        <= inv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_noninv_q <= err_noninv_d;
`ifdef DECONV_CHECK_EN
      err_mismatch_q <= err_mismatch_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign x_out      = {{(32-X_W){1'b0}}, x_q};
  assign err_noninv = err_noninv_q;
`ifdef DECONV_CHECK_EN
  assign err_mismatch = err_mismatch_q;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_deconvolution.sv
// Self-checking bench for deconvolution: directed vector table, multi-cycle
// corner sequences and randomized round-trips against a search-based model.
module tb_deconvolution;

`ifdef DECONV_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif
  localparam int FULL_LAT = CHECK_ON ? 8 : 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] y_in;
  logic [31:0] h_in;
  logic        busy;
  logic        done;
  logic [31:0] x_out;
  logic        err_noninv;
  logic        err_mismatch;

  int testsRun    = 0;
  int testsFailed = 0;

  deconvolution dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .y_in         (y_in),
    .h_in         (h_in),
    .busy         (busy),
    .done         (done),
    .x_out        (x_out),
    .err_noninv   (err_noninv),
    .err_mismatch (err_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [31:0] h;
    logic [31:0] x;
    bit          noninv;
    bit          mismatch;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  // Forward 4-tap nibble convolution, every output nibble reduced mod 16.
  function automatic logic [27:0] convolve(input logic [15:0] x, input logic [15:0] h);
    logic [27:0] y;
    int s;
    y = '0;
    for (int k = 0; k < 7; k++) begin
      s = 0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (i + j == k) s = s + int'(x[i*4 +: 4]) * int'(h[j*4 +: 4]);
      y[k*4 +: 4] = 4'(s % 16);
    end
    return y;
  endfunction

  // Finds each x nibble by trying all 16 values until the convolution matches y.
  function automatic void refModel(input logic [31:0] y, input logic [31:0] h,
                                   output logic [31:0] x, output bit ni, output bit mm);
    logic [15:0] xs;
    logic [27:0] yc;
    xs = '0;
    x  = '0;
    ni = 1'b0;
    mm = 1'b0;
    if (h[0] == 1'b0) begin
      ni = 1'b1;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 16; v++) begin
        xs[k*4 +: 4] = 4'(v);
        yc = convolve(xs, h[15:0]);
        if (yc[k*4 +: 4] == y[k*4 +: 4]) break;
      end
    end
    x = {16'b0, xs};
    yc = convolve(xs, h[15:0]);
    mm = CHECK_ON && (yc[27:16] != y[27:16]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Launches one job and waits for done; lat is -1 if done never arrives.
  task automatic applyStimulus(input logic [31:0] y, input logic [31:0] h,
                               output logic [31:0] x, output bit ni, output bit mm,
                               output int lat, output bit busyE0,
                               output bit doneTail, output bit busyTail);
    @(negedge clk);
    y_in  = y;
    h_in  = h;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    busyE0 = busy;
    lat    = -1;
    x      = '0;
    ni     = 1'b0;
    mm     = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        x   = x_out;
        ni  = err_noninv;
        mm  = err_mismatch;
        break;
      end
    end
    @(posedge clk);
    #1;
    doneTail = done;
    busyTail = busy;
  endtask

  initial begin
    logic [31:0] gx, ex, rx, rh, ry;
    bit          gni, gmm, eni, emm, bE0, dT, bT, sawDone, sawBusy;
    int          lat;
    logic [15:0] xr;

    rst   = 1'b1;
    start = 1'b0;
    y_in  = '0;
    h_in  = '0;

    vecs[0] = '{32'h00047531, 32'h00000011, 32'h00004321, 1'b0, 1'b0,     FULL_LAT};
    vecs[1] = '{32'h00000003, 32'h00000003, 32'h00000001, 1'b0, 1'b0,     FULL_LAT};
    vecs[2] = '{32'h0ABCDEF1, 32'h00000012, 32'h00000000, 1'b1, 1'b0,     1};
    vecs[3] = '{32'h00147531, 32'h00000011, 32'h00004321, 1'b0, CHECK_ON, FULL_LAT};
    vecs[4] = '{32'hF0047531, 32'hABCD0011, 32'h00004321, 1'b0, 1'b0,     FULL_LAT};
    vecs[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0,     1};

    #12;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset x_out", x_out, 32'd0);
    checkOutput("reset err_noninv", {31'b0, err_noninv}, 32'd0);
    checkOutput("reset err_mismatch", {31'b0, err_mismatch}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].y, vecs[i].h, gx, gni, gmm, lat, bE0, dT, bT);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d x_out", i), gx, vecs[i].x);
      checkOutput($sformatf("vec%0d err_noninv", i), {31'b0, gni}, {31'b0, vecs[i].noninv});
      checkOutput($sformatf("vec%0d err_mismatch", i), {31'b0, gmm}, {31'b0, vecs[i].mismatch});
      checkOutput($sformatf("vec%0d busy after start", i), {31'b0, bE0}, 32'd1);
      checkOutput($sformatf("vec%0d done pulse width", i), {31'b0, dT}, 32'd0);
      checkOutput($sformatf("vec%0d busy after done", i), {31'b0, bT}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d x_out held", i), x_out, vecs[i].x);
      checkOutput($sformatf("vec%0d noninv held", i), {31'b0, err_noninv}, {31'b0, vecs[i].noninv});
    end

    // A second start while busy must be dropped without disturbing the first job.
    @(negedge clk);
    y_in  = 32'h00047531;
    h_in  = 32'h00000011;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    y_in  = 32'h0ABCDEF3;
    h_in  = 32'h00000012;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    gx    = '0;
    gni   = 1'b1;
    for (int n = 4; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        gx  = x_out;
        gni = err_noninv;
        break;
      end
    end
    checkOutput("overlap latency", lat, FULL_LAT);
    checkOutput("overlap x_out", gx, 32'h00004321);
    checkOutput("overlap err_noninv", {31'b0, gni}, 32'd0);
    sawBusy = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (busy) sawBusy = 1'b1;
    end
    checkOutput("overlap not queued", {31'b0, sawBusy}, 32'd0);

    // Asynchronous reset in the middle of SOLVE aborts the job silently.
    @(negedge clk);
    y_in  = 32'h00047531;
    h_in  = 32'h00000011;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("progressive x_out", x_out, 32'h00000021);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort x_out", x_out, 32'd0);
    checkOutput("abort done", {31'b0, done}, 32'd0);
    checkOutput("abort errors", {30'b0, err_noninv, err_mismatch}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sawDone = 1'b0;
    sawBusy = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) sawDone = 1'b1;
      if (busy) sawBusy = 1'b1;
    end
    checkOutput("abort no done", {31'b0, sawDone}, 32'd0);
    checkOutput("abort stays idle", {31'b0, sawBusy}, 32'd0);

    // Round trip: convolve a random x with an odd-h0 kernel, then recover it.
    for (int it = 0; it < 1000; it++) begin
      xr = 16'($urandom);
      rh = $urandom;
      rh[0] = 1'b1;
      ry = {4'($urandom), convolve(xr, rh[15:0])};
      applyStimulus(ry, rh, gx, gni, gmm, lat, bE0, dT, bT);
      checkOutput($sformatf("rt%0d x_out", it), gx, {16'b0, xr});
      checkOutput($sformatf("rt%0d err_mismatch", it), {31'b0, gmm}, 32'd0);
      checkOutput($sformatf("rt%0d err_noninv", it), {31'b0, gni}, 32'd0);
      checkOutput($sformatf("rt%0d latency", it), lat, FULL_LAT);
    end

    // Arbitrary y and h, including even h0 and inconsistent upper nibbles.
    for (int it = 0; it < 200; it++) begin
      ry = $urandom;
      rh = $urandom;
      refModel(ry, rh, ex, eni, emm);
      applyStimulus(ry, rh, gx, gni, gmm, lat, bE0, dT, bT);
      checkOutput($sformatf("rnd%0d x_out", it), gx, ex);
      checkOutput($sformatf("rnd%0d err_noninv", it), {31'b0, gni}, {31'b0, eni});
      checkOutput($sformatf("rnd%0d err_mismatch", it), {31'b0, gmm}, {31'b0, emm});
      checkOutput($sformatf("rnd%0d latency", it), lat, eni ? 1 : FULL_LAT);
    end

    rx = '0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
